mux4_rr_arb: RTL and testbench

Round-robin select sequencer that sits directly upstream of the 4:1 mux cell and drives its S1/S0 select pins. Four requesters compete for the mux path. A registered arbiter grants one of them for a burst of beats, counts the beats accepted downstream, and holds the mux select stable for the whole burst. The block is the sequential control companion to the mux4 datapath cell in the 9-track 5V library.

---
 rtl/mux4_rr_arb_pkg.sv | 29 ++
 rtl/mux4_rr_arb_rr_pick4.sv | 47 ++++
 rtl/mux4_rr_arb.sv | 156 +++++++++++++++
 tb/tb_mux4_rr_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux4_rr_arb_pkg
// Shared types and helpers for the mux4 round-robin select sequencer.
//   state_t        : FSM states (IDLE, GRANT, GAP)
//   idx_t          : 2-bit requester / mux input index, {S1,S0} = index
//   PTR_RST        : reset value of the round-robin pointer (requester 0 wins first)
//   idx_to_onehot  : index -> one-hot grant vector
// -----------------------------------------------------------------------------
package mux4_rr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef logic [1:0] idx_t;

  localparam idx_t PTR_RST = 2'd3;

  // One-hot encode a requester index into a 4-bit grant vector.
  function automatic logic [3:0] idx_to_onehot(input idx_t idx);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arb_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Purely combinational 4-way round-robin picker. Finds the first set request
// bit searching cyclically from i_ptr+1, so requester i_ptr has lowest priority.
// Ports:
//   i_req   [3:0] : request vector
//   i_ptr   [1:0] : index of the most recent winner
//   o_valid       : at least one request is set
//   o_idx   [1:0] : winning index (0 when o_valid is low)
// -----------------------------------------------------------------------------
module rr_pick4
  import mux4_rr_arb_pkg::*;
(
  input  logic [3:0] i_req,
  input  idx_t       i_ptr,
  output logic       o_valid,
  output idx_t       o_idx
);

  idx_t       w_base;
  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  idx_t       w_off;

  // Rotate requests so the search start lands at bit 0, then priority-encode
  // the lowest set bit and rotate the offset back into an absolute index.
  always_comb begin
    w_base  = i_ptr + 2'd1;
    w_dbl   = {i_req, i_req};
    w_rot   = w_dbl[w_base +: 4];
    w_off   = 2'd0;
    o_valid = 1'b0;
    casez (w_rot)
      4'b???1: begin w_off = 2'd0; o_valid = 1'b1; end
      4'b??10: begin w_off = 2'd1; o_valid = 1'b1; end
      4'b?100: begin w_off = 2'd2; o_valid = 1'b1; end
      4'b1000: begin w_off = 2'd3; o_valid = 1'b1; end
      default: begin w_off = 2'd0; o_valid = 1'b0; end
    endcase
    if (o_valid) begin
      o_idx = w_base + w_off;
    end else begin
      o_idx = 2'd0;
    end
  end

endmodule

// File: rtl/mux4_rr_arb.sv
// -----------------------------------------------------------------------------
// mux4_rr_arb
// Round-robin select sequencer driving the S1/S0 pins of a 4:1 mux cell.
// One of four requesters is granted for a burst of LEN+1 beats; beats are
// counted on ACK and the select is held stable for the whole burst. A single
// GAP cycle with no grant separates bursts so the select changes glitch-free.
//
// Parameters:
//   LEN_W          : burst-length width, bursts of 1..2^LEN_W beats
// Ports:
//   CLK            : clock, rising edge
//   RST            : asynchronous active-high reset
//   REQ   [3:0]    : requests, requester i owns mux input Ii
//   LEN   [LEN_W-1:0] : burst length minus one, sampled in the grant cycle
//   ACK            : downstream accepted the current beat
//   S0, S1         : registered mux select, {S1,S0} = granted index
//   GNT   [3:0]    : registered one-hot grant, zero outside a burst
//   BUSY           : registered, high while a burst is in progress
//   LAST           : registered, high on the final beat of the burst
//
// Build option:
//   MUX4_RR_ARB_PARK_EN : when defined, S1/S0 stay parked on the last granted
//                         index through GAP and IDLE; otherwise they return
//                         to 00 on entry to GAP.
// -----------------------------------------------------------------------------
module mux4_rr_arb
  import mux4_rr_arb_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       REQ,
  input  logic [LEN_W-1:0] LEN,
  input  logic             ACK,
  output logic             S0,
  output logic             S1,
  output logic [3:0]       GNT,
  output logic             BUSY,
  output logic             LAST
);

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  idx_t             r_ptr;
  idx_t             r_sel;
  logic [3:0]       r_gnt;
  logic             r_busy;
  logic             r_last;

  logic             w_pick_valid;
  idx_t             w_pick_idx;
  logic             w_req_own;
  logic             w_cnt_zero;
  logic             w_beat;
  logic             w_to_gap;
  logic [LEN_W-1:0] w_cnt_dec;
  idx_t             w_sel_gap;

  rr_pick4 u_pick (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Select value applied when a burst ends: parked or returned to input 0.
`ifdef MUX4_RR_ARB_PARK_EN
  assign w_sel_gap = r_sel;
`else
  assign w_sel_gap = 2'd0;
`endif

  // Burst bookkeeping: a beat decrements CNT only while non-zero, and the
  // burst ends on the final ACKed beat or when the owner withdraws its request.
  always_comb begin
    w_req_own  = REQ[r_ptr];
    w_cnt_zero = (r_cnt == CNT_ZERO);
    w_cnt_dec  = r_cnt - CNT_ONE;
    if (r_state == ST_GRANT) begin
      w_beat   = ACK & ~w_cnt_zero;
      w_to_gap = (ACK & w_cnt_zero) | ~w_req_own;
    end else begin
      w_beat   = 1'b0;
      w_to_gap = 1'b0;
    end
  end

  // Arbitration FSM with counter, pointer and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_ptr   <= PTR_RST;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state <= ST_GRANT;
            r_cnt   <= LEN;
            r_ptr   <= w_pick_idx;
            r_sel   <= w_pick_idx;
            r_gnt   <= idx_to_onehot(w_pick_idx);
            r_busy  <= 1'b1;
            r_last  <= (LEN == CNT_ZERO);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_beat) begin
            r_cnt <= w_cnt_dec;
          end else begin
            r_cnt <= r_cnt;
          end
          if (w_to_gap) begin
            // Completion or abort; PTR keeps this winner either way.
            r_state <= ST_GAP;
            r_sel   <= w_sel_gap;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_beat) begin
            r_last <= (r_cnt == CNT_ONE);
          end else begin
            r_last <= r_last;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_sel   <= 2'd0;
          r_gnt   <= 4'b0000;
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign S0   = r_sel[0];
  assign S1   = r_sel[1];
  assign GNT  = r_gnt;
  assign BUSY = r_busy;
  assign LAST = r_last;

endmodule

// File: tb/tb_mux4_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arb
// Self-checking bench for mux4_rr_arb: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// burst-level behavioural model (owner, beats remaining, phase).
// -----------------------------------------------------------------------------
module tb_mux4_rr_arb;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] LEN;
  logic       ACK;
  logic       S0, S1, BUSY, LAST;
  logic [3:0] GNT;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  mux4_rr_arb #(.LEN_W(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LEN(LEN), .ACK(ACK),
    .S0(S0), .S1(S1), .GNT(GNT), .BUSY(BUSY), .LAST(LAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef MUX4_RR_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (burst level) ----------------
  int m_phase = 0;   // 0 = idle, 1 = granted, 2 = gap
  int m_owner = 0;
  int m_ptr   = 3;
  int m_left  = 0;   // beats still owed, including the current one
  int m_sel   = 0;

  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_phase = 0; m_owner = 0; m_ptr = 3; m_left = 0; m_sel = 0;
      end else if (m_phase == 0) begin
        if (REQ != 4'b0000) begin
          bit found;
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (!found && REQ[c]) begin
              found = 1'b1;
              m_owner = c;
            end
          end
          m_ptr   = m_owner;
          m_sel   = m_owner;
          m_left  = int'(LEN) + 1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        bit done;
        done = 1'b0;
        if (ACK) begin
          m_left = m_left - 1;
          if (m_left == 0) done = 1'b1;
        end
        if (!REQ[m_owner]) done = 1'b1;
        if (done) begin
          m_phase = 2;
          if (!PARK) m_sel = 0;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        chk("mdl_gnt",  GNT,  (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
        chk("mdl_sel",  {S1, S0}, m_sel);
        chk("mdl_busy", BUSY, (m_phase == 1) ? 32'd1 : 32'd0);
        chk("mdl_last", LAST, (m_phase == 1 && m_left == 1) ? 32'd1 : 32'd0);
      end
    end
  end

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK); #2 RST = 1'b1;
    @(negedge CLK); #2 RST = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  bit ack_pat   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int park_sel;
    park_sel = PARK ? 2 : 0;
    RST = 1'b1; REQ = 4'b0000; LEN = 4'd0; ACK = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    chk("rst_gnt", GNT, 4'b0000);
    chk("rst_sel", {S1, S0}, 2'b00);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_last", LAST, 1'b0);
    cmp_en = 1'b1;

    // Single requester, LEN=2, ACK held
    REQ = 4'b0001; LEN = 4'd2; ACK = 1'b1;
    next_cycle();
    chk("t1_gnt", GNT, 4'b0001); chk("t1_sel", {S1, S0}, 2'b00);
    chk("t1_busy1", BUSY, 1'b1); chk("t1_last1", LAST, 1'b0);
    next_cycle();
    chk("t1_busy2", BUSY, 1'b1); chk("t1_last2", LAST, 1'b0);
    next_cycle();
    chk("t1_busy3", BUSY, 1'b1); chk("t1_last3", LAST, 1'b1);
    next_cycle();
    chk("t1_gap_gnt", GNT, 4'b0000); chk("t1_gap_busy", BUSY, 1'b0);
    REQ = 4'b0000;
    next_cycle();

    // All requesting, single-beat bursts: rotation 0,1,2,3,0 from reset
    do_reset();
    REQ = 4'b1111; LEN = 4'd0; ACK = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      chk("t2_gnt", GNT, 32'd1 << exp_order[i]);
      chk("t2_sel", {S1, S0}, exp_order[i]);
      chk("t2_last", LAST, 1'b1);
      next_cycle();
      chk("t2_gap", GNT, 4'b0000);
      next_cycle();
      chk("t2_idle", BUSY, 1'b0);
    end

    // Requester 2, LEN=3, ACK pattern 1,0,0,1,1,1; also select parking
    REQ = 4'b0100; LEN = 4'd3; ACK = 1'b1;
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      chk("t3_busy", BUSY, 1'b1);
      chk("t3_last", LAST, (k == 5) ? 32'd1 : 32'd0);
      chk("t3_sel", {S1, S0}, 2'b10);
      ACK = ack_pat[k];
      next_cycle();
    end
    chk("t3_gap_busy", BUSY, 1'b0);
    chk("t3_gap_gnt", GNT, 4'b0000);
    chk("t3_gap_sel", {S1, S0}, park_sel);
    REQ = 4'b0000;
    next_cycle();
    chk("t3_idle_sel", {S1, S0}, park_sel);

    // Abort after two ACKed beats, then fairness from PTR=1
    REQ = 4'b0010; LEN = 4'd5; ACK = 1'b1;
    next_cycle();
    chk("t4_gnt", GNT, 4'b0010);
    next_cycle();
    next_cycle();
    chk("t4_busy", BUSY, 1'b1); chk("t4_last", LAST, 1'b0);
    REQ = 4'b0000; ACK = 1'b0;
    next_cycle();
    chk("t4_abort_busy", BUSY, 1'b0); chk("t4_abort_gnt", GNT, 4'b0000);
    REQ = 4'b0011;
    next_cycle();
    next_cycle();
    chk("t4_regrant", GNT, 4'b0001);
    REQ = 4'b0000;
    next_cycle();
    next_cycle();

    // Asynchronous reset mid-burst with CNT=3
    REQ = 4'b0001; LEN = 4'd5; ACK = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    chk("t5_pre_busy", BUSY, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("t5_rst_gnt", GNT, 4'b0000);
    chk("t5_rst_sel", {S1, S0}, 2'b00);
    chk("t5_rst_busy", BUSY, 1'b0);
    chk("t5_rst_last", LAST, 1'b0);
    REQ = 4'b1000;
    @(negedge CLK); #2 RST = 1'b0;
    next_cycle();
    chk("t5_gnt3", GNT, 4'b1000);
    chk("t5_sel3", {S1, S0}, 2'b11);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 599) == 0) begin
        #2 RST = 1'b1;
        @(negedge CLK); #2 RST = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) REQ = 4'($urandom_range(0, 15));
      LEN = 4'($urandom_range(0, 15));
      ACK = ($urandom_range(0, 3) != 0);
    end

    @(negedge CLK);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
